// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry layout.
package regfile_pkg;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 64;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/decoder_5to32.sv
// Register-number to one-hot decoder; all-zero when not enabled.
module decoder_5to32
   import regfile_pkg::*;
(
   input  logic [ADDR_W-1:0]   addr,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end
endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back FIFO feeding the register array, one commit per cycle,
// with a youngest-match forwarding lookup over the buffered entries.
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     hold,
   output logic [NUM_REGS-1:0]      writeEnable,
   output logic [DATA_W-1:0]        writeData,
   input  logic [ADDR_W-1:0]        query_addr,
   output logic                     query_hit,
   output logic [DATA_W-1:0]        query_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         commit_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   wb_entry_t          entries [DEPTH];
   logic [DEPTH-1:0]   entryValid;
   logic [PTR_W-1:0]   headPtr, tailPtr;
   logic [OCC_W-1:0]   occ;
   logic [CNT_W-1:0]   commitCnt;
   logic               doPush, doPop;
   wb_entry_t          headEntry;

   assign in_ready     = (occ != OCC_W'(DEPTH));
   // Zero-register writes complete the handshake but never occupy a slot.
   assign doPush       = in_valid && in_ready && (in_addr != ZERO_REG);
   assign doPop        = (occ != '0) && !hold;
   assign headEntry    = entries[headPtr];
   assign writeData    = doPop ? headEntry.data : '0;
   assign count        = occ;
   assign commit_count = commitCnt;

   decoder_5to32 uDec (
      .addr   (headEntry.addr),
      .en     (doPop),
      .onehot (writeEnable)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         entryValid <= '0;
         headPtr    <= '0;
         tailPtr    <= '0;
         occ        <= '0;
         commitCnt  <= '0;
      end else begin
         // Push and pop never share a slot: pop needs occ>0, push needs occ<DEPTH.
         if (doPush) begin
            entries[tailPtr]    <= '{addr: in_addr, data: in_data};
            entryValid[tailPtr] <= 1'b1;
            tailPtr             <= tailPtr + PTR_W'(1);
         end
         if (doPop) begin
            entryValid[headPtr] <= 1'b0;
            headPtr             <= headPtr + PTR_W'(1);
            commitCnt           <= commitCnt + CNT_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Walk oldest to youngest so the last match left standing is the youngest.
   logic [PTR_W-1:0] fwdIdx;
   always_comb begin
      query_hit  = 1'b0;
      query_data = '0;
      fwdIdx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwdIdx = headPtr + PTR_W'(i);
         if (entryValid[fwdIdx] && (entries[fwdIdx].addr == query_addr) &&
             (query_addr != ZERO_REG)) begin
            query_hit  = 1'b1;
            query_data = entries[fwdIdx].data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed-vector bench for regfile_write_queue.
module tb_regfile_write_queue;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [63:0] in_data;
   logic        hold;
   logic [31:0] writeEnable;
   logic [63:0] writeData;
   logic [4:0]  query_addr;
   logic        query_hit;
   logic [63:0] query_data;
   logic [2:0]  count;
   logic [15:0] commit_count;

   int checks = 0;
   int errors = 0;

   regfile_write_queue #(.DEPTH(4), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .hold         (hold),
      .writeEnable  (writeEnable),
      .writeData    (writeData),
      .query_addr   (query_addr),
      .query_hit    (query_hit),
      .query_data   (query_data),
      .count        (count),
      .commit_count (commit_count)
   );

   always #5 clk = ~clk;

   task step;
      @(posedge clk);
      #1;
   endtask

   task test_reset;
      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      hold = 1'b0; query_addr = '0;
      #3;
      checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || writeEnable !== 32'd0 ||
          writeData !== 64'd0 || query_hit !== 1'b0 || query_data !== 64'd0 ||
          commit_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: count=%0d rdy=%b we=%h wd=%h hit=%b qd=%h cc=%0d, need 0/1/0/0/0/0/0",
                  count, in_ready, writeEnable, writeData, query_hit, query_data, commit_count);
      end
      step;
      reset = 1'b0;
      step;
   endtask

   task test_single;
      in_valid = 1'b1; in_addr = 5'd3; in_data = 64'hDEAD_BEEF;
      step;
      in_valid = 1'b0;
      #1;
      checks++;
      if (writeEnable !== 32'h0000_0008 || writeData !== 64'hDEAD_BEEF || count !== 3'd1) begin
         errors++;
         $display("FAIL single_drain: we=%h wd=%h count=%0d, need 00000008 deadbeef 1",
                  writeEnable, writeData, count);
      end
      step;
      checks++;
      if (writeEnable !== 32'd0 || count !== 3'd0 || commit_count !== 16'd1) begin
         errors++;
         $display("FAIL single_after: we=%h count=%0d cc=%0d, need 0 0 1",
                  writeEnable, count, commit_count);
      end
   endtask

   task test_fill;
      logic [31:0] expWe [5];
      logic [63:0] expWd [5];
      logic [2:0]  expCnt [5];
      expWe  = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h200};
      expWd  = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd77};
      expCnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_addr = 5'(i); in_data = 64'(10 + i);
         #1;
         checks++;
         if (in_ready !== 1'b1 || writeEnable !== 32'd0) begin
            errors++;
            $display("FAIL fill_ready[%0d]: rdy=%b we=%h, need 1 0", i, in_ready, writeEnable);
         end
         step;
      end
      in_addr = 5'd4; in_data = 64'd99; query_addr = 5'd2;
      #1;
      checks++;
      if (in_ready !== 1'b0 || count !== 3'd4 || query_hit !== 1'b1 || query_data !== 64'd12) begin
         errors++;
         $display("FAIL full_query: rdy=%b count=%0d hit=%b qd=%0d, need 0 4 1 12",
                  in_ready, count, query_hit, query_data);
      end
      step;
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL full_block: count=%0d, need 4", count);
      end
      // Drain; the first cycle is full with a pop so the push must still be refused.
      hold = 1'b0; in_addr = 5'd9; in_data = 64'd77;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 2);
         #1;
         checks++;
         if (writeEnable !== expWe[i] || writeData !== expWd[i] ||
             (i == 0 && in_ready !== 1'b0) || (i == 1 && in_ready !== 1'b1)) begin
            errors++;
            $display("FAIL drain[%0d]: we=%h wd=%0d rdy=%b, need %h %0d",
                     i, writeEnable, writeData, in_ready, expWe[i], expWd[i]);
         end
         step;
         checks++;
         if (count !== expCnt[i]) begin
            errors++;
            $display("FAIL drain_count[%0d]: count=%0d, need %0d", i, count, expCnt[i]);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (commit_count !== 16'd6) begin
         errors++;
         $display("FAIL fill_commits: cc=%0d, need 6", commit_count);
      end
   endtask

   task test_same_addr;
      hold = 1'b1; query_addr = 5'd5;
      in_valid = 1'b1; in_addr = 5'd5; in_data = 64'd1;
      #1;
      checks++;
      if (query_hit !== 1'b0) begin
         errors++;
         $display("FAIL fwd_not_yet: hit=%b, need 0", query_hit);
      end
      step;
      in_data = 64'd2;
      step;
      in_valid = 1'b0;
      #1;
      checks++;
      if (query_hit !== 1'b1 || query_data !== 64'd2) begin
         errors++;
         $display("FAIL fwd_youngest: hit=%b qd=%0d, need 1 2", query_hit, query_data);
      end
      hold = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         checks++;
         if (writeEnable !== 32'h20 || writeData !== 64'(i)) begin
            errors++;
            $display("FAIL same_order[%0d]: we=%h wd=%0d, need 00000020 %0d", i, writeEnable, writeData, i);
         end
         step;
      end
      checks++;
      if (commit_count !== 16'd8 || count !== 3'd0) begin
         errors++;
         $display("FAIL same_commits: cc=%0d count=%0d, need 8 0", commit_count, count);
      end
   endtask

   task test_zero_reg;
      query_addr = 5'd31;
      in_valid = 1'b1; in_addr = 5'd31; in_data = 64'hFFFF;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_ready: rdy=%b, need 1", in_ready);
      end
      step;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (count !== 3'd0 || writeEnable !== 32'd0 || query_hit !== 1'b0 || commit_count !== 16'd8) begin
            errors++;
            $display("FAIL zero_reg[%0d]: count=%0d we=%h hit=%b cc=%0d, need 0 0 0 8",
                     i, count, writeEnable, query_hit, commit_count);
         end
         step;
      end
   endtask

   task test_async_reset;
      hold = 1'b1; query_addr = 5'd10;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 64'(100 + i);
         step;
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (count !== 3'd4 || query_hit !== 1'b1 || query_data !== 64'd100) begin
         errors++;
         $display("FAIL pre_reset: count=%0d hit=%b qd=%0d, need 4 1 100", count, query_hit, query_data);
      end
      #2;
      reset = 1'b1;
      hold  = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || writeEnable !== 32'd0 || in_ready !== 1'b1 ||
          query_hit !== 1'b0 || commit_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: count=%0d we=%h rdy=%b hit=%b cc=%0d, need 0 0 1 0 0",
                  count, writeEnable, in_ready, query_hit, commit_count);
      end
      #10;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if (writeEnable !== 32'd0 || count !== 3'd0 || commit_count !== 16'd0) begin
            errors++;
            $display("FAIL post_reset[%0d]: we=%h count=%0d cc=%0d, need 0 0 0",
                     i, writeEnable, count, commit_count);
         end
      end
   endtask

   task test_back_to_back;
      int bubbles;
      bubbles = 0;
      hold = 1'b0; in_addr = 5'd7;
      for (int i = 0; i <= 65536; i++) begin
         in_valid = 1'b1; in_data = 64'(i);
         #1;
         if (in_ready !== 1'b1) bubbles++;
         if (i > 0 && (writeEnable !== 32'h80 || writeData !== 64'(i - 1))) bubbles++;
         step;
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (bubbles !== 0 || writeEnable !== 32'h80 || writeData !== 64'd65536) begin
         errors++;
         $display("FAIL stream: bubbles=%0d last_we=%h last_wd=%0d, need 0 00000080 65536",
                  bubbles, writeEnable, writeData);
      end
      step;
      checks++;
      if (count !== 3'd0 || commit_count !== 16'd1) begin
         errors++;
         $display("FAIL stream_wrap: count=%0d cc=%0d, need 0 1", count, commit_count);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_same_addr;
      test_zero_reg;
      test_async_reset;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
